// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port A arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int RAM_AW = 30;
    localparam int RAM_DW = 32;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way picker for RAM port A arbitration.
// ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring M0.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       force_other,
    output logic       winner,
    output logic       valid
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    always_comb begin
        valid  = |req;
        winner = M0;
        if (req == 2'b10) begin
            winner = M1;
        end else if (req == 2'b11) begin
            // A burst-cap handover overrides fixed priority for one arbitration
            winner = (force_other | RR_EN) ? ~last_win : M0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for port A of the shared instruction/data RAM, with capped lock bursts.
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed M0 priority in IDLE.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int AW        = RAM_AW,
    parameter int DW        = RAM_DW
)(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_byteena,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_byteena,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_wren,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic [3:0]    ram_byteena,
    input  logic [DW-1:0] ram_q
);

    arb_state_e    state;
    logic [7:0]    burst_cnt;
    logic          last_win;
    logic          force_other;
    logic          rd_pending;
    logic          rd_owner;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    be_q;

    logic          pick_win;
    logic          pick_vld;
    logic          win;
    logic          gnt;
    logic          win_we;
    logic          win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [3:0]    win_be;
    logic          cap_hit;

    ram_arb_pick u_pick (
        .req         ({m1_req, m0_req}),
        .last_win    (last_win),
        .force_other (force_other),
        .winner      (pick_win),
        .valid       (pick_vld)
    );

    always_comb begin
        win = pick_win;
        gnt = pick_vld;
        case (state)
            OWN_M0: begin win = M0; gnt = m0_req; end
            OWN_M1: begin win = M1; gnt = m1_req; end
            default: ;
        endcase
        // No access may reach the RAM while reset is asserted
        gnt = gnt & reset_n;
    end

    assign win_we    = (win == M1) ? m1_we      : m0_we;
    assign win_lock  = (win == M1) ? m1_lock    : m0_lock;
    assign win_addr  = (win == M1) ? m1_addr    : m0_addr;
    assign win_wdata = (win == M1) ? m1_wdata   : m0_wdata;
    assign win_be    = (win == M1) ? m1_byteena : m0_byteena;

    assign cap_hit = (({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST));

    assign m0_gnt      = gnt & (win == M0);
    assign m1_gnt      = gnt & (win == M1);
    assign ram_wren    = gnt & win_we;
    assign ram_address = gnt ? win_addr  : addr_q;
    assign ram_data    = gnt ? win_wdata : wdata_q;
    assign ram_byteena = gnt ? win_be    : be_q;

    assign m0_rvalid = rd_pending & (rd_owner == M0);
    assign m1_rvalid = rd_pending & (rd_owner == M1);
    assign m0_rdata  = m0_rvalid ? ram_q : m0_rdata_q;
    assign m1_rdata  = m1_rvalid ? ram_q : m1_rdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            burst_cnt   <= 8'd0;
            last_win    <= M1;
            force_other <= 1'b0;
            rd_pending  <= 1'b0;
            rd_owner    <= M0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            rd_pending <= gnt & ~win_we;
            if (m0_rvalid) m0_rdata_q <= ram_q;
            if (m1_rvalid) m1_rdata_q <= ram_q;
            if (gnt) begin
                last_win <= win;
                if (!win_we) rd_owner <= win;
                if (state == IDLE) begin
                    force_other <= 1'b0;
                    if (win_lock && MAX_BURST > 1) begin
                        state     <= (win == M1) ? OWN_M1 : OWN_M0;
                        burst_cnt <= 8'd1;
                    end else if (win_lock) begin
                        force_other <= 1'b1;
                    end
                end else if (!win_lock || cap_hit) begin
                    // Only a release forced by the cap hands priority to the other master
                    state       <= IDLE;
                    burst_cnt   <= 8'd0;
                    force_other <= win_lock;
                end else begin
                    burst_cnt <= burst_cnt + 8'd1;
                end
            end
        end
    end

    // Last winner's drive values, held on idle cycles
    always_ff @(posedge clock) begin
        if (gnt) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            be_q    <= win_be;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized scoreboard bench for ram_port_arbiter with a behavioural RAM and arbitration model.
module tb_ram_port_arbiter;

    localparam int MAXB = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;

    typedef struct {
        int          m;
        int          due;
        logic [31:0] d;
    } rexp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [29:0] m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic [3:0]  m0_byteena = '0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [29:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_byteena = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_q = '0;

    always #5 clock = ~clock;

    ram_port_arbiter #(.MAX_BURST(MAXB), .AW(30), .DW(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_byteena(m0_byteena),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_byteena(m1_byteena),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
        .ram_byteena(ram_byteena), .ram_q(ram_q)
    );

    // Behavioural single-port RAM: registered read, byte-enabled write
    logic [31:0] ram_mem [256];
    logic        s_wr = 1'b0;
    logic [7:0]  s_a = '0;
    logic [31:0] s_d = '0;
    logic [3:0]  s_be = '0;

    always @(negedge clock) begin
        s_wr = ram_wren;
        s_a  = ram_address[7:0];
        s_d  = ram_data;
        s_be = ram_byteena;
    end

    always @(posedge clock) begin
        ram_q <= ram_mem[s_a];
        if (s_wr)
            for (int i = 0; i < 4; i++)
                if (s_be[i]) ram_mem[s_a][8*i +: 8] <= s_d[8*i +: 8];
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [31:0] held [2];
    bit          exp_rv [2];
    rexp_t       expq [$];
    int          own = -1;
    int          cnt = 0;
    int          last = 1;
    bit          force_o = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_on = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic mreq_t mk(input logic rq, input logic we, input logic lk,
                                 input logic [29:0] ad, input logic [31:0] wd, input logic [3:0] be);
        mreq_t r;
        r.req = rq; r.we = we; r.lock = lk; r.addr = ad; r.wdata = wd; r.be = be;
        return r;
    endfunction

    task automatic step(input mreq_t a, input mreq_t b, input bit rst);
        mreq_t       x [2];
        int          w;
        logic        wi;
        logic [31:0] mask;
        @(posedge clock);
        #1;
        x[0] = a;
        x[1] = b;
        reset_n = !rst;
        m0_req = a.req; m0_we = a.we; m0_lock = a.lock;
        m0_addr = a.addr; m0_wdata = a.wdata; m0_byteena = a.be;
        m1_req = b.req; m1_we = b.we; m1_lock = b.lock;
        m1_addr = b.addr; m1_wdata = b.wdata; m1_byteena = b.be;
        w = -1;
        if (rst) begin
            own = -1; cnt = 0; last = 1; force_o = 1'b0;
            expq.delete();
            held[0] = '0;
            held[1] = '0;
        end else if (own < 0) begin
            if (a.req && b.req) w = (force_o || RR) ? 1 - last : 0;
            else if (a.req)     w = 0;
            else if (b.req)     w = 1;
        end else if (x[own[0]].req) begin
            w = own;
        end
        wi = w[0];
        @(negedge clock);
        chk("m0_gnt", 64'(m0_gnt), 64'(w == 0));
        chk("m1_gnt", 64'(m1_gnt), 64'(w == 1));
        chk("ram_wren", 64'(ram_wren), 64'((w >= 0) && x[wi].we));
        if (w >= 0) begin
            chk("ram_address", 64'(ram_address), 64'(x[wi].addr));
            if (x[wi].we) begin
                chk("ram_data", 64'(ram_data), 64'(x[wi].wdata));
                chk("ram_byteena", 64'(ram_byteena), 64'(x[wi].be));
                mask = '0;
                for (int i = 0; i < 4; i++) if (x[wi].be[i]) mask[8*i +: 8] = 8'hFF;
                ref_mem[x[wi].addr[7:0]] = (ref_mem[x[wi].addr[7:0]] & ~mask) | (x[wi].wdata & mask);
            end else begin
                expq.push_back('{m: w, due: cyc + 1, d: ref_mem[x[wi].addr[7:0]]});
            end
            last = w;
            if (own < 0) begin
                force_o = 1'b0;
                if (x[wi].lock) begin
                    if (MAXB > 1) begin own = w; cnt = 1; end
                    else force_o = 1'b1;
                end
            end else if (!x[wi].lock) begin
                own = -1; cnt = 0;
            end else if (cnt + 1 == MAXB) begin
                own = -1; cnt = 0; force_o = 1'b1;
            end else begin
                cnt++;
            end
        end
    endtask

    // Monitor: pops the expected read response in the cycle it is due
    always @(negedge clock) begin
        if (mon_on) begin
            exp_rv[0] = 1'b0;
            exp_rv[1] = 1'b0;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                exp_rv[expq[0].m[0]] = 1'b1;
                held[expq[0].m[0]] = expq[0].d;
                void'(expq.pop_front());
            end
            chk("m0_rvalid", 64'(m0_rvalid), 64'(exp_rv[0]));
            chk("m1_rvalid", 64'(m1_rvalid), 64'(exp_rv[1]));
            chk("m0_rdata", 64'(m0_rdata), 64'(held[0]));
            chk("m1_rdata", 64'(m1_rdata), 64'(held[1]));
        end
    end

    mreq_t idle_r, ra, rb;

    initial begin
        idle_r = '0;
        held[0] = '0;
        held[1] = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            ram_mem[i] = ref_mem[i];
        end
        ref_mem[8'h10] = 32'h11223344; ram_mem[8'h10] = 32'h11223344;
        ref_mem[8'h20] = 32'hCAFE0020; ram_mem[8'h20] = 32'hCAFE0020;

        repeat (2) @(negedge clock);
        chk("reset_m0_gnt", 64'(m0_gnt), 64'(0));
        chk("reset_m1_gnt", 64'(m1_gnt), 64'(0));
        chk("reset_m0_rvalid", 64'(m0_rvalid), 64'(0));
        chk("reset_m1_rvalid", 64'(m1_rvalid), 64'(0));
        chk("reset_m0_rdata", 64'(m0_rdata), 64'(0));
        chk("reset_m1_rdata", 64'(m1_rdata), 64'(0));
        chk("reset_ram_wren", 64'(ram_wren), 64'(0));
        mon_on = 1'b1;

        // Partial write then read-back merges the old upper bytes
        step(mk(1, 1, 0, 30'h10, 32'hDEADBEEF, 4'b0011), idle_r, 0);
        step(mk(1, 0, 0, 30'h10, 32'h0, 4'hF), idle_r, 0);
        step(idle_r, idle_r, 0);
        chk("merge_rdata", 64'(m0_rdata), 64'(32'h1122BEEF));

        // Simultaneous unlocked requests
        repeat (4) step(mk(1, 0, 0, 30'h3, 32'h0, 4'hF), mk(1, 0, 0, 30'h4, 32'h0, 4'hF), 0);

        // M1 locked burst capped while M0 waits
        step(idle_r, mk(1, 1, 1, 30'h5, 32'h55, 4'hF), 0);
        repeat (4) step(mk(1, 0, 0, 30'h6, 32'h0, 4'hF), mk(1, 1, 1, 30'h5, 32'h56, 4'hF), 0);

        // Read then write to the same word on the next cycle
        step(idle_r, mk(1, 0, 0, 30'h20, 32'h0, 4'hF), 0);
        step(mk(1, 1, 0, 30'h20, 32'h0BADF00D, 4'hF), idle_r, 0);
        chk("old_word", 64'(m1_rdata), 64'(32'hCAFE0020));
        step(idle_r, mk(1, 0, 0, 30'h20, 32'h0, 4'hF), 0);
        step(idle_r, idle_r, 0);
        chk("new_word", 64'(m1_rdata), 64'(32'h0BADF00D));

        // Reset straight after a locked M0 read drops the pending data
        step(mk(1, 0, 1, 30'h7, 32'h0, 4'hF), idle_r, 0);
        step(mk(1, 1, 1, 30'h7, 32'h77, 4'hF), mk(1, 0, 0, 30'h8, 32'h0, 4'hF), 1);
        step(idle_r, mk(1, 0, 0, 30'h8, 32'h0, 4'hF), 0);

        // Idle cycles inside an M0 burst neither release nor count
        step(mk(1, 0, 1, 30'h9, 32'h0, 4'hF), idle_r, 0);
        repeat (3) step(idle_r, mk(1, 0, 0, 30'hA, 32'h0, 4'hF), 0);
        repeat (3) step(mk(1, 0, 1, 30'h9, 32'h0, 4'hF), mk(1, 0, 0, 30'hA, 32'h0, 4'hF), 0);
        step(mk(1, 0, 0, 30'h9, 32'h0, 4'hF), mk(1, 0, 0, 30'hA, 32'h0, 4'hF), 0);

        for (int i = 0; i < 600; i++) begin
            ra = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    30'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
            rb = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    30'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
            step(ra, rb, $urandom_range(0, 149) == 0);
        end

        step(idle_r, idle_r, 0);
        step(idle_r, idle_r, 0);
        chk("reads_drained", 64'(expq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
